bus_cu: RTL and testbench
=========================

Name: bus_cu

Overview:
- Parametrised control unit for the shared-bus datapath; successor to the fixed 16-bit CU.
- Accepts one micro-instruction at a time over a valid/ready handshake.
- Moves each operand across a single internal bus (cu_data) and executes into a register file of NREGS entries, or into the accumulator (ac_data).
- Adds a configurable width, register count, ADD/SUB with carry/zero flags, instruction back-pressure and a register read-back port.

Parameters:
- WIDTH, 16: data width of the bus, registers and accumulator (4..64).
- NREGS, 4: number of general registers; power of two, 2..16.
- AW = log2(NREGS): localparam, register index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  enable; when 0, no new instruction is accepted.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  unit can accept an instruction.
- instr_op  in  3  opcode.
- instr_dst  in  AW  destination register index.
- instr_src  in  AW  source register index.
- instr_imm  in  WIDTH  immediate value.
- cu_data  out  WIDTH  internal bus value (registered).
- ac_data  out  WIDTH  accumulator (registered).
- carry  out  1  carry/borrow flag.
- zero  out  1  accumulator-zero flag.
- done  out  1  one-cycle pulse when an instruction completes.
- rd_idx  in  AW  read-back register index.
- rd_data  out  WIDTH  combinational value of reg[rd_idx].

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All registers, cu_data, ac_data, carry, zero and done cleared to 0.
  - Reset asserted mid-instruction abandons that instruction; no partial write survives.
- States: IDLE -> XFER -> EXEC -> IDLE.
- IDLE:
  - instr_ready = en.
  - On a clock edge with instr_valid & instr_ready: latch op/dst/src/imm and go to XFER.
  - instr_ready = 0 in XFER and EXEC.
- XFER (1 cycle): at exit edge, cu_data <= operand:
  - imm for LDI.
  - ac_data for STA.
  - reg[src] for MOV/LDA/ADD/SUB.
  - 0 for NOP/CLR.
- EXEC (1 cycle): at exit edge, perform the write from cu_data, set done=1, return to IDLE.
  - done is 0 on all other cycles.
- Opcodes:
  - 000 NOP: no write.
  - 001 LDI: reg[dst] <= imm.
  - 010 MOV: reg[dst] <= reg[src].
  - 011 LDA: ac <= reg[src].
  - 100 STA: reg[dst] <= ac.
  - 101 ADD: {carry, ac} <= ac + bus, as a (WIDTH+1)-bit sum.
  - 110 SUB: ac <= ac - bus; carry = 1 when ac < bus, unsigned borrow.
  - 111 CLR: ac <= 0, carry <= 0.
- Flags:
  - zero updates on LDA/ADD/SUB/CLR to (new ac == 0).
  - carry updates only on ADD/SUB/CLR.
  - Flags hold otherwise.
- Timing: accept at edge k; cu_data valid after edge k+1; result and done visible after edge k+2. Next accept is possible at edge k+3.
- Register aliasing: src==dst on MOV is legal and leaves the register unchanged.
- en handling:
  - Dropping en mid-instruction does not stall; the current instruction completes.
  - A request held with en=0 is not accepted and no state changes.
- Hold behaviour:
  - cu_data holds its last value in IDLE.
  - instr_* is ignored outside the accept edge; changing it after accept has no effect.
- Arithmetic wraps modulo 2^WIDTH.

Test Plan:
- Reset: hold reset=0 for 85 ns with clk period 200 ns → all outputs 0, instr_ready=0 while en=0; set en=1 → instr_ready=1.
- LDI r1=0x1234, then MOV r2←r1 → rd_idx=2 gives 0x1234. During MOV XFER, cu_data=0x1234. done pulses once per instruction, 3 cycles apart.
- WIDTH=16, ac=0xFFFF, then ADD with r=0x0001 → ac=0x0000, carry=1, zero=1. Then SUB with r=0x0001 → ac=0xFFFF, carry=1, zero=0.
- LDA r1 (0x1234), STA r3, CLR → r3=0x1234, ac=0, carry=0, zero=1.
- Hold instr_valid=1 with en=0 for 5 cycles → no done, registers unchanged. Raise en → accepted on the next edge.
- Assert reset during EXEC of LDI r0=0xBEEF → r0=0, done stays 0, state IDLE after release. Repeat with WIDTH=8, NREGS=8: LDI r7=0xAB, ADD → wraps at 8 bits.

Source files
------------

// File: rtl/bus_cu.sv
// Shared-bus control unit: moves one operand per micro-instruction over cu_data into a register or the accumulator.
// Latency: accept at edge k, bus at k+1, result/done at k+2, next accept at k+3.
// Backpressure: instr_ready is high only in IDLE with en set; instr_* is sampled on the accept edge only.
module bus_cu #(
    parameter int WIDTH = 16,
    parameter int NREGS = 4,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [AW-1:0]    instr_dst,
    input  logic [AW-1:0]    instr_src,
    input  logic [WIDTH-1:0] instr_imm,
    output logic [WIDTH-1:0] cu_data,
    output logic [WIDTH-1:0] ac_data,
    output logic             carry,
    output logic             zero,
    output logic             done,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data
);
    typedef enum logic [1:0] {IDLE, XFER, EXEC} state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_LDA = 3'b011;
    localparam logic [2:0] OP_STA = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    state_t           state;
    logic [2:0]       op_q;
    logic [AW-1:0]    dst_q;
    logic [AW-1:0]    src_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    assign instr_ready = en && (state == IDLE);
    assign rd_data     = regs[rd_idx];

    // The extra top bit of diff is the unsigned borrow (ac < bus).
    assign sum  = {1'b0, ac_data} + {1'b0, cu_data};
    assign diff = {1'b0, ac_data} - {1'b0, cu_data};

    always_comb begin
        operand = '0;
        case (op_q)
            OP_LDI:                         operand = imm_q;
            OP_STA:                         operand = ac_data;
            OP_MOV, OP_LDA, OP_ADD, OP_SUB: operand = regs[src_q];
            default:                        operand = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_q    <= OP_NOP;
            dst_q   <= '0;
            src_q   <= '0;
            imm_q   <= '0;
            cu_data <= '0;
            ac_data <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        op_q  <= instr_op;
                        dst_q <= instr_dst;
                        src_q <= instr_src;
                        imm_q <= instr_imm;
                        state <= XFER;
                    end
                end
                XFER: begin
                    cu_data <= operand;
                    state   <= EXEC;
                end
                EXEC: begin
                    case (op_q)
                        OP_LDI, OP_MOV, OP_STA: regs[dst_q] <= cu_data;
                        OP_LDA: begin
                            ac_data <= cu_data;
                            zero    <= (cu_data == '0);
                        end
                        OP_ADD: begin
                            ac_data <= sum[WIDTH-1:0];
                            carry   <= sum[WIDTH];
                            zero    <= (sum[WIDTH-1:0] == '0);
                        end
                        OP_SUB: begin
                            ac_data <= diff[WIDTH-1:0];
                            carry   <= diff[WIDTH];
                            zero    <= (diff[WIDTH-1:0] == '0);
                        end
                        OP_CLR: begin
                            ac_data <= '0;
                            carry   <= 1'b0;
                            zero    <= 1'b1;
                        end
                        default: ;
                    endcase
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_cu.sv
module tb_bus_cu;
    localparam logic [2:0] NOP = 3'd0, LDI = 3'd1, MOV = 3'd2, LDA = 3'd3;
    localparam logic [2:0] STA = 3'd4, ADD = 3'd5, SUB = 3'd6, CLR = 3'd7;

    logic clk = 1'b0;
    always #100 clk = ~clk;

    // 16-bit, 4-register instance
    logic        reset, en, instr_valid, instr_ready, carry, zero, done;
    logic [2:0]  instr_op;
    logic [1:0]  instr_dst, instr_src, rd_idx;
    logic [15:0] instr_imm, cu_data, ac_data, rd_data;

    // 8-bit, 8-register instance
    logic        reset_b, en_b, valid_b, ready_b, carry_b, zero_b, done_b;
    logic [2:0]  op_b, dst_b, src_b, rd_idx_b;
    logic [7:0]  imm_b, cu_data_b, ac_b, rd_data_b;

    bus_cu #(.WIDTH(16), .NREGS(4)) dut (
        .clk(clk), .reset(reset), .en(en), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_dst(instr_dst), .instr_src(instr_src), .instr_imm(instr_imm),
        .cu_data(cu_data), .ac_data(ac_data), .carry(carry), .zero(zero), .done(done),
        .rd_idx(rd_idx), .rd_data(rd_data)
    );

    bus_cu #(.WIDTH(8), .NREGS(8)) dut_b (
        .clk(clk), .reset(reset_b), .en(en_b), .instr_valid(valid_b), .instr_ready(ready_b),
        .instr_op(op_b), .instr_dst(dst_b), .instr_src(src_b), .instr_imm(imm_b),
        .cu_data(cu_data_b), .ac_data(ac_b), .carry(carry_b), .zero(zero_b), .done(done_b),
        .rd_idx(rd_idx_b), .rd_data(rd_data_b)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  dst;
        logic [1:0]  src;
        logic [15:0] imm;
        logic [15:0] bus;
        logic [15:0] ac;
        logic        c;
        logic        z;
        logic [1:0]  ridx;
        logic [15:0] rval;
    } vec_t;

    vec_t tbl [14];

    // Called at a negedge; returns at the negedge after the done edge.
    task automatic run_instr(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] src,
                             input logic [15:0] imm, input logic [15:0] bus);
        en = 1'b1;
        instr_valid = 1'b1;
        instr_op = op; instr_dst = dst; instr_src = src; instr_imm = imm;
        #1 chk("ready_before_accept", instr_ready, 1'b1);
        @(negedge clk);
        instr_valid = 1'b0;
        instr_op = ~op; instr_dst = ~dst; instr_src = ~src; instr_imm = ~imm;
        chk("ready_in_xfer", instr_ready, 1'b0);
        chk("done_in_xfer", done, 1'b0);
        @(negedge clk);
        chk("bus_operand", cu_data, bus);
        chk("done_in_exec", done, 1'b0);
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
    endtask

    task automatic run_b(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                         input logic [7:0] imm);
        valid_b = 1'b1;
        op_b = op; dst_b = dst; src_b = src; imm_b = imm;
        @(negedge clk);
        valid_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("w8_done", done_b, 1'b1);
    endtask

    initial begin
        tbl[0]  = '{LDI, 2'd1, 2'd0, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 2'd1, 16'h1234};
        tbl[1]  = '{MOV, 2'd2, 2'd1, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0, 2'd2, 16'h1234};
        tbl[2]  = '{LDI, 2'd0, 2'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 2'd0, 16'hFFFF};
        tbl[3]  = '{LDA, 2'd0, 2'd0, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 2'd0, 16'hFFFF};
        tbl[4]  = '{LDI, 2'd3, 2'd0, 16'h0001, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 2'd3, 16'h0001};
        tbl[5]  = '{ADD, 2'd0, 2'd3, 16'h0000, 16'h0001, 16'h0000, 1'b1, 1'b1, 2'd3, 16'h0001};
        tbl[6]  = '{SUB, 2'd0, 2'd3, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 2'd3, 16'h0001};
        tbl[7]  = '{LDA, 2'd0, 2'd1, 16'h0000, 16'h1234, 16'h1234, 1'b1, 1'b0, 2'd1, 16'h1234};
        tbl[8]  = '{STA, 2'd3, 2'd0, 16'h0000, 16'h1234, 16'h1234, 1'b1, 1'b0, 2'd3, 16'h1234};
        tbl[9]  = '{CLR, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'd3, 16'h1234};
        tbl[10] = '{MOV, 2'd2, 2'd2, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b1, 2'd2, 16'h1234};
        tbl[11] = '{NOP, 2'd1, 2'd0, 16'h5555, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'd1, 16'h1234};
        tbl[12] = '{ADD, 2'd0, 2'd1, 16'h0000, 16'h1234, 16'h1234, 1'b0, 1'b0, 2'd1, 16'h1234};
        tbl[13] = '{SUB, 2'd0, 2'd1, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b1, 2'd1, 16'h1234};

        reset = 1'b0; en = 1'b0; instr_valid = 1'b0;
        instr_op = NOP; instr_dst = '0; instr_src = '0; instr_imm = '0; rd_idx = '0;
        reset_b = 1'b0; en_b = 1'b0; valid_b = 1'b0;
        op_b = NOP; dst_b = '0; src_b = '0; imm_b = '0; rd_idx_b = '0;

        #85;
        chk("rst_cu_data", cu_data, 16'h0);
        chk("rst_ac", ac_data, 16'h0);
        chk("rst_flags", {carry, zero, done}, 3'b000);
        chk("rst_rd_data", rd_data, 16'h0);
        chk("rst_ready_en0", instr_ready, 1'b0);
        reset = 1'b1;
        #1 en = 1'b1;
        #1 chk("ready_en1", instr_ready, 1'b1);

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].imm, tbl[i].bus);
            rd_idx = tbl[i].ridx;
            #1;
            chk($sformatf("row%0d_ac", i), ac_data, tbl[i].ac);
            chk($sformatf("row%0d_carry", i), carry, tbl[i].c);
            chk($sformatf("row%0d_zero", i), zero, tbl[i].z);
            chk($sformatf("row%0d_reg", i), rd_data, tbl[i].rval);
        end

        // Request held with en low is never taken.
        en = 1'b0; instr_valid = 1'b1;
        instr_op = LDI; instr_dst = 2'd1; instr_src = 2'd0; instr_imm = 16'hDEAD; rd_idx = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("en0_ready", instr_ready, 1'b0);
            chk("en0_no_done", done, 1'b0);
        end
        chk("en0_reg_kept", rd_data, 16'h1234);
        en = 1'b1;
        #1 chk("en1_ready", instr_ready, 1'b1);
        @(negedge clk);
        chk("en1_accepted", instr_ready, 1'b0);
        en = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("en_drop_done", done, 1'b1);
        chk("en_drop_write", rd_data, 16'hDEAD);
        en = 1'b1;

        // Reset during EXEC abandons the write.
        instr_valid = 1'b1; instr_op = LDI; instr_dst = 2'd0; instr_imm = 16'hBEEF; rd_idx = 2'd0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #10;
        chk("rstx_r0", rd_data, 16'h0);
        chk("rstx_done", done, 1'b0);
        chk("rstx_cu_data", cu_data, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        chk("rstx_r0_after", rd_data, 16'h0);
        chk("rstx_done_after", done, 1'b0);
        chk("rstx_idle", instr_ready, 1'b1);
        @(negedge clk);
        chk("rstx_done_later", done, 1'b0);
        chk("rstx_r0_later", rd_data, 16'h0);

        // 8-bit / 8-register instance: wrap at 8 bits.
        reset_b = 1'b1; en_b = 1'b1;
        @(negedge clk);
        run_b(LDI, 3'd7, 3'd0, 8'hAB);
        rd_idx_b = 3'd7;
        #1 chk("w8_r7", rd_data_b, 8'hAB);
        run_b(LDA, 3'd0, 3'd7, 8'h00);
        chk("w8_lda_ac", ac_b, 8'hAB);
        run_b(LDI, 3'd6, 3'd0, 8'h60);
        run_b(ADD, 3'd0, 3'd6, 8'h00);
        chk("w8_add_ac", ac_b, 8'h0B);
        chk("w8_add_carry", carry_b, 1'b1);
        chk("w8_add_zero", zero_b, 1'b0);
        run_b(STA, 3'd5, 3'd0, 8'h00);
        rd_idx_b = 3'd5;
        #1 chk("w8_sta_r5", rd_data_b, 8'h0B);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
